// File: rtl/lab_nios_system_jtag_debug_ocimem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab_nios_system_jtag_debug_ocimem_pkg
// Description : Shared definitions for the JTAG debug on-chip memory block:
//               FSM state encoding, RAM geometry and jdo field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package lab_nios_system_jtag_debug_ocimem_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int BE_W      = DATA_W / 8;

    // jdo field positions
    localparam int JDO_W         = 38;
    localparam int JDO_CLR_OVF   = 35;
    localparam int JDO_DATA_MSB  = 34;
    localparam int JDO_DATA_LSB  = 3;
    localparam int JDO_ADDR_MSB  = 33;
    localparam int JDO_ADDR_LSB  = 26;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_J_RD = 2'd1,
        ST_J_WR = 2'd2,
        ST_C_RD = 2'd3
    } state_t;

    // Monitor address increment; the natural width overflow gives 255 -> 0.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lab_nios_system_jtag_debug_ocimem_ram.sv
`default_nettype none
// ============================================================================
// Module      : lab_nios_system_jtag_debug_ocimem_ram
// Description : 256x32 single-port RAM with byte enables and a registered
//               (one-cycle) read port. Contents are not initialised.
// Ports       : clk, reset (blocks writes while high), we, be, addr, wdata,
//               rdata (valid the cycle after addr is presented)
// Revision    : 1.0 - initial release
// ============================================================================
module lab_nios_system_jtag_debug_ocimem_ram
    import lab_nios_system_jtag_debug_ocimem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we && !reset) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/lab_nios_system_jtag_debug_ocimem.sv
`default_nettype none
// ============================================================================
// Module      : lab_nios_system_jtag_debug_ocimem
// Description : JTAG debug on-chip memory. One RAM shared between a JTAG
//               monitor path (address load, write, read-increment) and a CPU
//               Avalon slave port. JTAG has priority over the CPU.
// Ports       : clk, reset (async, active high)
//               jdo, take_action_ocimem_a/b, take_no_action_ocimem_a : JTAG
//               address, chipselect, read, write, writedata, byteenable,
//               readdata, waitrequest                                : CPU
//               MonDReg, MonAReg, jtag_busy, jtag_ovf                : monitor
// Revision    : 1.0 - initial release
// ============================================================================
module lab_nios_system_jtag_debug_ocimem
    import lab_nios_system_jtag_debug_ocimem_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    input  logic [BE_W-1:0]   byteenable,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    output logic [DATA_W-1:0] MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_ovf
);

    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_mon_a;
    logic [DATA_W-1:0] r_mon_d, r_readdata;
    logic              r_ovf;

    logic              w_open, w_any_pulse, w_acc_a, w_acc_b, w_acc_n, w_drop;
    logic              w_req, w_grant, w_wr_grant, w_rd_grant;
    logic              w_ram_we;
    logic [BE_W-1:0]   w_ram_be;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata;
    logic [DATA_W-1:0] w_jdo_data;
    logic [ADDR_W-1:0] w_jdo_addr;
    logic              w_unused;

    assign w_jdo_data = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    assign w_jdo_addr = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
    assign w_unused   = ^{jdo[JDO_W-1:JDO_CLR_OVF+1], jdo[JDO_DATA_LSB-1:0]};

    // JTAG pulses are only accepted when no JTAG op is in flight; a CPU read
    // completing in C_RD does not block them.
    assign w_open      = (r_state == ST_IDLE) || (r_state == ST_C_RD);
    assign w_any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_acc_a     = w_open & take_action_ocimem_a;
    assign w_acc_b     = w_open & take_action_ocimem_b & ~take_action_ocimem_a;
    assign w_acc_n     = w_open & take_no_action_ocimem_a & ~take_action_ocimem_a
                                & ~take_action_ocimem_b;
    // Dropped: every losing pulse when open, every pulse when busy.
    assign w_drop      = w_open ? ((take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                                 | (take_action_ocimem_b & take_no_action_ocimem_a))
                                : w_any_pulse;

    assign w_req      = chipselect & (read | write);
    assign w_grant    = (r_state == ST_IDLE) & ~w_any_pulse & w_req;
    assign w_wr_grant = w_grant & write;
    assign w_rd_grant = w_grant & ~write;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, RAM port steering and CPU handshake
    always_comb begin
        w_next_state = r_state;
        w_ram_we     = 1'b0;
        w_ram_be     = byteenable;
        w_ram_addr   = address;
        w_ram_wdata  = writedata;
        waitrequest  = w_req & ~(w_wr_grant | (r_state == ST_C_RD));
        jtag_busy    = (r_state == ST_J_RD) || (r_state == ST_J_WR);

        case (r_state)
            ST_IDLE, ST_C_RD: begin
                if (w_acc_b)         w_next_state = ST_J_WR;
                else if (w_acc_n)    w_next_state = ST_J_RD;
                else if (w_rd_grant) w_next_state = ST_C_RD;
                else                 w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase

        if (w_acc_b || w_acc_n) begin
            w_ram_addr = r_mon_a;
        end
        if (w_acc_b) begin
            w_ram_we    = 1'b1;
            w_ram_be    = {BE_W{1'b1}};
            w_ram_wdata = w_jdo_data;
        end else if (w_wr_grant) begin
            w_ram_we = 1'b1;
        end
    end

    // Monitor and CPU data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mon_a    <= '0;
            r_mon_d    <= '0;
            r_readdata <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_acc_a) begin
                r_mon_a <= w_jdo_addr;
            end else if (w_acc_b || (r_state == ST_J_RD)) begin
                r_mon_a <= addr_inc(r_mon_a);
            end

            if (w_acc_b) begin
                r_mon_d <= w_jdo_data;
            end else if (r_state == ST_J_RD) begin
                r_mon_d <= w_ram_rdata;
            end

            if (r_state == ST_C_RD) begin
                r_readdata <= w_ram_rdata;
            end

            // A drop in the same cycle as a clearing address load wins, so
            // the lost action is never hidden.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_acc_a && jdo[JDO_CLR_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign MonAReg  = r_mon_a;
    assign MonDReg  = r_mon_d;
    assign readdata = r_readdata;
    assign jtag_ovf = r_ovf;

    lab_nios_system_jtag_debug_ocimem_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_ram_we),
        .be    (w_ram_be),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_lab_nios_system_jtag_debug_ocimem.sv
`default_nettype none
// ============================================================================
// Module      : tb_lab_nios_system_jtag_debug_ocimem
// Description : Scoreboard bench for the JTAG debug on-chip memory. A
//               transaction-level model (array + monitor address/data) pushes
//               expected results; independent monitors compare them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lab_nios_system_jtag_debug_ocimem;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        jtag_busy, jtag_ovf;

    lab_nios_system_jtag_debug_ocimem dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .waitrequest(waitrequest),
        .MonDReg(MonDReg), .MonAReg(MonAReg),
        .jtag_busy(jtag_busy), .jtag_ovf(jtag_ovf)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [256];
    logic [7:0]  m_maddr;
    logic [31:0] m_mdr;
    bit          m_ovf;
    logic [31:0] cpu_q [$];
    logic [39:0] jtag_q [$];

    int checks   = 0;
    int failures = 0;

    function automatic void check(string name, logic [39:0] got, logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, got, exp);
        end
    endfunction

    // ---------------- monitors ----------------
    initial begin : mon_cpu
        bit hs;
        forever begin
            @(negedge clk); #2;
            hs = !reset && chipselect && read && !write && !waitrequest;
            @(posedge clk); #1;
            if (hs && !reset) begin
                if (cpu_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL cpu_rd_unexpected: actual readdata=%h required=no read", readdata);
                end else begin
                    check("cpu_readdata", {8'h0, readdata}, {8'h0, cpu_q.pop_front()});
                end
            end
        end
    end

    initial begin : mon_jtag
        bit prev;
        int cnt;
        prev = 1'b0;
        cnt  = 0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                prev = 1'b0;
                cnt  = 0;
            end else begin
                if (jtag_busy) begin
                    cnt++;
                end else if (prev) begin
                    check("jtag_busy_cycles", 40'(cnt), 40'd1);
                    if (jtag_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL jtag_op_unexpected: actual MonDReg=%h MonAReg=%h required=no op",
                                 MonDReg, MonAReg);
                    end else begin
                        check("jtag_mon_regs", {MonDReg, MonAReg}, jtag_q.pop_front());
                    end
                    cnt = 0;
                end
                prev = jtag_busy;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input bit pa, input bit pb, input bit pn, input logic [37:0] j);
        @(negedge clk);
        take_action_ocimem_a    = pa;
        take_action_ocimem_b    = pb;
        take_no_action_ocimem_a = pn;
        jdo = j;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    function automatic logic [37:0] jdo_rand();
        logic [37:0] j;
        j = {$urandom, $urandom};
        return j;
    endfunction

    task automatic jtag_load(input logic [7:0] a, input bit clr);
        logic [37:0] j;
        j = jdo_rand();
        j[33:26] = a;
        j[35] = clr;
        m_maddr = a;
        if (clr) m_ovf = 1'b0;
        pulse(1'b1, 1'b0, 1'b0, j);
        #1 check("jtag_ovf_after_load", {39'h0, jtag_ovf}, {39'h0, m_ovf});
    endtask

    task automatic jtag_write(input logic [31:0] d);
        logic [37:0] j;
        j = jdo_rand();
        j[34:3] = d;
        m_mem[m_maddr] = d;
        m_mdr = d;
        m_maddr = m_maddr + 8'd1;
        jtag_q.push_back({m_mdr, m_maddr});
        pulse(1'b0, 1'b1, 1'b0, j);
    endtask

    task automatic jtag_read();
        m_mdr = m_mem[m_maddr];
        m_maddr = m_maddr + 8'd1;
        jtag_q.push_back({m_mdr, m_maddr});
        pulse(1'b0, 1'b0, 1'b1, jdo_rand());
    endtask

    // CPU access; optionally a JTAG write pulse arrives in the same first cycle.
    task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit with_b, input logic [31:0] bd,
                          output int waits);
        bit done;
        logic [37:0] j;
        @(negedge clk);
        chipselect = 1'b1; read = ~wr; write = wr;
        address = a; writedata = d; byteenable = be;
        if (with_b) begin
            j = jdo_rand();
            j[34:3] = bd;
            jdo = j;
            take_action_ocimem_b = 1'b1;
            m_mem[m_maddr] = bd;
            m_mdr = bd;
            m_maddr = m_maddr + 8'd1;
            jtag_q.push_back({m_mdr, m_maddr});
        end
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
        end else begin
            cpu_q.push_back(m_mem[a]);
        end
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (waitrequest) waits++;
            else done = 1'b1;
            @(negedge clk);
            take_action_ocimem_b = 1'b0;
        end
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL cpu_timeout: actual=no grant required=grant within 20 cycles");
        end
    endtask

    initial begin : stim
        int w;
        logic [37:0] j;
        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0;
        m_maddr = '0; m_mdr = '0; m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_MonAReg",  {32'h0, MonAReg}, 40'h0);
        check("rst_MonDReg",  {8'h0, MonDReg}, 40'h0);
        check("rst_readdata", {8'h0, readdata}, 40'h0);
        check("rst_ovf_busy", {38'h0, jtag_ovf, jtag_busy}, 40'h0);
        reset = 1'b0;

        // Fill the whole RAM through JTAG; the address wraps back to 0.
        jtag_load(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) jtag_write($urandom);

        // Address load then JTAG write
        jtag_load(8'h10, 1'b0);
        jtag_write(32'hDEADBEEF);
        cpu_op(1'b0, 8'h10, '0, 4'h0, 1'b0, '0, w);
        check("cpu_rd_waits", 40'(w), 40'd1);

        // Read-increment across the 255 -> 0 wrap
        jtag_load(8'hFF, 1'b0);
        jtag_write(32'h12345678);
        jtag_load(8'hFF, 1'b0);
        jtag_read();

        // CPU byte-lane write then read
        cpu_op(1'b1, 8'h05, 32'h0, 4'hF, 1'b0, '0, w);
        check("cpu_wr_waits", 40'(w), 40'd0);
        cpu_op(1'b1, 8'h05, 32'hAABBCCDD, 4'b0011, 1'b0, '0, w);
        check("cpu_wr_waits", 40'(w), 40'd0);
        cpu_op(1'b0, 8'h05, '0, 4'h0, 1'b0, '0, w);
        check("cpu_rd_waits", 40'(w), 40'd1);
        check("model_byte_merge", {8'h0, m_mem[5]}, {8'h0, 32'h0000CCDD});

        // Collision: JTAG write to the address the CPU is reading
        jtag_load(8'h20, 1'b0);
        cpu_op(1'b0, 8'h20, '0, 4'h0, 1'b1, 32'hCAFEF00D, w);
        check("collision_waits", 40'(w), 40'd3);

        // Back-to-back JTAG writes: the second is dropped
        j = jdo_rand(); j[34:3] = 32'h01020304;
        @(negedge clk);
        take_action_ocimem_b = 1'b1; jdo = j;
        m_mem[m_maddr] = 32'h01020304; m_mdr = 32'h01020304; m_maddr = m_maddr + 8'd1;
        jtag_q.push_back({m_mdr, m_maddr});
        @(negedge clk);
        j = jdo_rand(); jdo = j;
        m_ovf = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        #1 check("ovf_set", {39'h0, jtag_ovf}, 40'h1);
        jtag_load(8'h30, 1'b1);

        // Simultaneous pulses: address load wins, the rest are dropped
        j = jdo_rand(); j[33:26] = 8'h40; j[35] = 1'b0;
        m_maddr = 8'h40; m_ovf = 1'b1;
        pulse(1'b1, 1'b1, 1'b1, j);
        #1 check("ovf_multi", {39'h0, jtag_ovf}, 40'h1);
        jtag_read();
        jtag_load(8'h41, 1'b1);

        // Randomised mix
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: jtag_load(8'($urandom), 1'($urandom));
                1: jtag_write($urandom);
                2: jtag_read();
                3: begin
                    cpu_op(1'b1, 8'($urandom), $urandom, 4'($urandom), 1'b0, '0, w);
                    check("rnd_wr_waits", 40'(w), 40'd0);
                end
                default: begin
                    cpu_op(1'b0, 8'($urandom), '0, 4'h0, 1'b0, '0, w);
                    check("rnd_rd_waits", 40'(w), 40'd1);
                end
            endcase
        end

        // Reset while a JTAG read is in flight
        jtag_load(8'hFF, 1'b0);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_jrd_MonDReg", {8'h0, MonDReg}, 40'h0);
        check("rst_jrd_MonAReg", {32'h0, MonAReg}, 40'h0);
        check("rst_jrd_busy", {39'h0, jtag_busy}, 40'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_maddr = '0; m_mdr = '0; m_ovf = 1'b0;
        jtag_load(8'hFF, 1'b0);
        jtag_read();

        repeat (5) @(negedge clk);
        check("cpu_q_drained", 40'(cpu_q.size()), 40'd0);
        check("jtag_q_drained", 40'(jtag_q.size()), 40'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab_nios_system_jtag_debug_ocimem.md
LAB_NIOS_SYSTEM_JTAG_DEBUG_OCIMEM -- requirements
Module: lab_nios_system_jtag_debug_ocimem

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset: clk, reset.
REQ-002 Port list, one per line as name, direction, width, meaning:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- jdo  in  38  JTAG data from sysclk stage
- take_action_ocimem_a  in  1  address load pulse
- take_action_ocimem_b  in  1  JTAG write pulse
- take_no_action_ocimem_a  in  1  JTAG read-increment pulse
- address  in  8  CPU word address
- chipselect, read, write  in  1 each  CPU Avalon controls
- writedata  in  32  CPU write data
- byteenable  in  4  CPU byte lanes
- readdata  out  32  CPU read data
- waitrequest  out  1  CPU stall
- MonDReg  out  32  monitor data register, to JTAG tck stage
- MonAReg  out  8  monitor word address
- jtag_busy  out  1  JTAG op in flight
- jtag_ovf  out  1  sticky dropped-action flag

Function
REQ-003 SHALL own one 256x32 single-port RAM with byte enables, 1-cycle registered read.
REQ-004 FSM states: IDLE, J_RD, J_WR, C_RD.
REQ-005 JTAG pulses are accepted in IDLE and C_RD; jtag_busy = (state==J_RD | state==J_WR).
REQ-006 take_action_ocimem_a accepted at cycle N: MonAReg <= jdo[33:26]; if jdo[35]=1, jtag_ovf <= 0; state unchanged.
REQ-007 take_action_ocimem_b accepted at N: RAM write at MonAReg, all lanes, data jdo[34:3]; MonDReg <= jdo[34:3]; MonAReg <= MonAReg+1; state J_WR for one cycle, then IDLE.
REQ-008 take_no_action_ocimem_a accepted at N: RAM read at MonAReg; state J_RD at N+1; MonDReg <= RAM data at end of N+1; MonAReg +1 at end of N+1; IDLE at N+2.
REQ-009 MonAReg increment SHALL wrap 255 -> 0.
REQ-010 More than one JTAG pulse in one cycle: priority is a > b > no_action_a; each lower pulse is dropped and sets jtag_ovf.
REQ-011 Any JTAG pulse arriving in J_RD or J_WR is dropped and sets jtag_ovf.
REQ-012 CPU request = chipselect & (read | write). It is granted only in IDLE with no JTAG pulse that cycle.
REQ-013 CPU write: on grant, RAM write honours byteenable; waitrequest=0 in the grant cycle.
REQ-014 CPU read: grant cycle issues the RAM read with waitrequest=1 and the state goes to C_RD. In C_RD, readdata <= RAM data and waitrequest=0.
REQ-015 A JTAG pulse accepted in C_RD still completes the CPU read that cycle; next state is J_RD or J_WR per REQ-007/008.
REQ-016 waitrequest = CPU request & ~(write granted | state==C_RD); it is combinational.
REQ-017 The CPU path never modifies MonAReg or MonDReg.

Reset
REQ-018 Reset assertion: state=IDLE, MonAReg=0, MonDReg=0, readdata=0, jtag_ovf=0, jtag_busy=0.
REQ-019 RAM writes are suppressed while reset=1; RAM contents are not initialised.
REQ-020 Reset mid-J_RD or mid-C_RD aborts the operation; no register update occurs after reset deasserts.

Structure
REQ-021 Shared package holds the FSM state enum, RAM depth (256), address width (8), data width (32), and jdo field bit positions.
REQ-022 Sub-module lab_nios_system_jtag_debug_ocimem_ram SHALL contain the RAM; the FSM and registers are in the top.

Verification
REQ-023 Address load: take_action_ocimem_a with jdo[33:26]=0x10, then take_action_ocimem_b with jdo[34:3]=0xDEADBEEF -> RAM[0x10]=0xDEADBEEF, MonAReg=0x11, jtag_busy high 1 cycle.
REQ-024 Read-increment: RAM[0xFF]=0x12345678, MonAReg=0xFF, take_no_action_ocimem_a -> MonDReg=0x12345678 at N+2, MonAReg=0x00.
REQ-025 CPU write/read: write 0xAABBCCDD to address 5, byteenable=4'b0011, over prior 0 -> read returns 0x0000CCDD; waitrequest high exactly 1 cycle on the read.
REQ-026 Collision: CPU read pending in IDLE while take_action_ocimem_b arrives -> JTAG wins; CPU waitrequest stays high until granted later; data is correct.
REQ-027 Overflow: take_action_ocimem_b pulses in consecutive cycles -> second is dropped and jtag_ovf=1; take_action_ocimem_a with jdo[35]=1 -> jtag_ovf=0.
REQ-028 Reset during J_RD -> MonDReg=0, MonAReg=0, state IDLE; RAM[0xFF] is unchanged.
